// File: rtl/udiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : udiv_pkg                                                    |
// | Brief  : Shared types and helpers for the sequential unsigned        |
// |          restoring divider.                                          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package udiv_pkg;

    // FSM encoding: only IDLE and RUN, since the result is a held flag.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } udiv_state_t;

    // The iteration counter must be able to hold the value WIDTH itself.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage : udiv_pkg
`default_nettype wire

// File: rtl/udivider_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : udivider_if                                                 |
// | Brief  : Operand / result handshake bundle of the unsigned divider.  |
// |          The master drives start/A/B, the slave (divider) returns    |
// |          Q/R and the status flags.                                   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface udivider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             valid_out;
    logic             busy_out;
    logic             dbz_out;

    modport master (
        output start, A, B,
        input  Q, R, valid_out, busy_out, dbz_out
    );

    modport slave (
        input  start, A, B,
        output Q, R, valid_out, busy_out, dbz_out
    );
endinterface : udivider_if
`default_nettype wire

// File: rtl/udiv_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : udiv_step                                                   |
// | Brief  : One restoring-division step: shift the next dividend bit    |
// |          into the partial remainder, trial-subtract the divisor and  |
// |          keep the difference only if it did not go negative.         |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module udiv_step #(
    parameter int WIDTH = 4
) (
    input  wire logic [WIDTH:0]   i_rem,
    input  wire logic             i_msb,
    input  wire logic [WIDTH-1:0] i_divisor,
    output logic      [WIDTH:0]   o_rem,
    output logic                  o_qbit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;
    logic           w_unused_top;

    // The stored remainder never exceeds WIDTH bits between steps, so its
    // top bit is shifted out; the extra bit only matters for the trial.
    assign w_unused_top = i_rem[WIDTH];

    assign w_shift = {i_rem[WIDTH-1:0], i_msb};
    assign w_trial = w_shift - {1'b0, i_divisor};

    // Top bit of the WIDTH+1 bit difference acts as the borrow/sign.
    assign o_qbit = ~w_trial[WIDTH];
    assign o_rem  = o_qbit ? w_trial : w_shift;

endmodule : udiv_step
`default_nettype wire

// File: rtl/udivider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : udivider                                                    |
// | Brief  : Sequential unsigned restoring divider, Q = A / B and        |
// |          R = A % B, one quotient bit per clock MSB first. Shares the |
// |          start/busy/valid handshake of the shift-add multiplier.     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module udivider
    import udiv_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    udivider_if.slave  bus
);

    localparam int CW = cnt_width(WIDTH);

    udiv_state_t      r_state;
    udiv_state_t      w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quot;
    logic             r_dbz;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_dbz_out;
    logic             r_valid;
    logic [WIDTH:0]   w_rem_next;
    logic             w_qbit;
    logic             w_iter;
    logic             w_last;

    udiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem     (r_rem),
        .i_msb     (r_dividend[WIDTH-1]),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_next),
        .o_qbit    (w_qbit)
    );

    // State register; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: start always (re)enters RUN, the final step exits.
    always_comb begin
        w_state_next = r_state;
        w_iter       = 1'b0;
        w_last       = 1'b0;
        if (bus.start) begin
            w_state_next = ST_RUN;
        end else if (r_state == ST_RUN) begin
            w_iter = 1'b1;
            if (r_cnt == CW'(1)) begin
                w_last       = 1'b1;
                w_state_next = ST_IDLE;
            end
        end
    end

    // Datapath: operand load, one restoring step per cycle, result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_dbz      <= 1'b0;
            r_q        <= '0;
            r_r        <= '0;
            r_dbz_out  <= 1'b0;
            r_valid    <= 1'b0;
        end else if (bus.start) begin
            // Published result stays visible; only the valid flag drops.
            r_cnt      <= CW'(WIDTH);
            r_dividend <= bus.A;
            r_divisor  <= bus.B;
            r_rem      <= '0;
            r_quot     <= '0;
            r_dbz      <= (bus.B == '0);
            r_valid    <= 1'b0;
        end else if (w_iter) begin
            r_cnt      <= r_cnt - CW'(1);
            r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
            r_rem      <= w_rem_next;
            r_quot     <= {r_quot[WIDTH-2:0], w_qbit};
            if (w_last) begin
                r_q       <= {r_quot[WIDTH-2:0], w_qbit};
                r_r       <= w_rem_next[WIDTH-1:0];
                r_dbz_out <= r_dbz;
                r_valid   <= 1'b1;
            end
        end
    end

    assign bus.Q         = r_q;
    assign bus.R         = r_r;
    assign bus.dbz_out   = r_dbz_out;
    assign bus.valid_out = r_valid;
    assign bus.busy_out  = (r_state == ST_RUN);

endmodule : udivider
`default_nettype wire

// File: tb/tb_udivider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_udivider                                                 |
// | Brief  : Self-checking bench for udivider at WIDTH=4 and WIDTH=8,    |
// |          scored against plain / and % arithmetic.                    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_udivider;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    udivider_if #(.WIDTH(4)) if4 ();
    udivider_if #(.WIDTH(8)) if8 ();

    udivider #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    udivider #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain division, with B=0 defined as Q=all ones, R=A.
    function automatic logic [7:0] ref_q(input logic [7:0] a, input logic [7:0] b, input int w);
        logic [7:0] ones;
        ones = 8'((1 << w) - 1);
        return (b == 0) ? ones : 8'(a / b);
    endfunction

    function automatic logic [7:0] ref_r(input logic [7:0] a, input logic [7:0] b);
        return (b == 0) ? a : 8'(a % b);
    endfunction

    // All drive tasks start and end just after a falling edge.
    task automatic launch4(input logic [3:0] a, input logic [3:0] b);
        if4.start = 1'b1; if4.A = a; if4.B = b;
        @(negedge clk);
    endtask

    task automatic drain4(output int nbusy, output bit timeout);
        if4.start = 1'b0; if4.A = 4'($urandom); if4.B = 4'($urandom);
        nbusy = 0; timeout = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (if4.busy_out) nbusy++;
            if (if4.valid_out) begin timeout = 1'b0; break; end
            @(negedge clk);
        end
    endtask

    task automatic launch8(input logic [7:0] a, input logic [7:0] b);
        if8.start = 1'b1; if8.A = a; if8.B = b;
        @(negedge clk);
    endtask

    task automatic drain8(output int nbusy, output bit timeout);
        if8.start = 1'b0; if8.A = 8'($urandom); if8.B = 8'($urandom);
        nbusy = 0; timeout = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (if8.busy_out) nbusy++;
            if (if8.valid_out) begin timeout = 1'b0; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({if4.Q, if4.R, if4.valid_out, if4.busy_out, if4.dbz_out} !== 11'h0) begin
            n_err++;
            $display("FAIL reset4: Q=%0d R=%0d v=%0b b=%0b z=%0b, want all 0",
                     if4.Q, if4.R, if4.valid_out, if4.busy_out, if4.dbz_out);
        end
        n_vec++;
        if ({if8.Q, if8.R, if8.valid_out, if8.busy_out, if8.dbz_out} !== 19'h0) begin
            n_err++;
            $display("FAIL reset8: Q=%0d R=%0d v=%0b b=%0b z=%0b, want all 0",
                     if8.Q, if8.R, if8.valid_out, if8.busy_out, if8.dbz_out);
        end
    endtask

    task automatic test_basic();
        int nb; bit to;
        launch4(4'd13, 4'd3);
        drain4(nb, to);
        n_vec++;
        if (to || nb != 4) begin
            n_err++;
            $display("FAIL basic_busy: busy cycles=%0d timeout=%0b, want 4/0", nb, to);
        end
        n_vec++;
        if ({if4.Q, if4.R, if4.dbz_out} !== {4'd4, 4'd1, 1'b0}) begin
            n_err++;
            $display("FAIL basic_result: Q=%0d R=%0d z=%0b, want 4 1 0", if4.Q, if4.R, if4.dbz_out);
        end
        repeat (5) @(negedge clk);
        n_vec++;
        if ({if4.valid_out, if4.Q, if4.R} !== {1'b1, 4'd4, 4'd1}) begin
            n_err++;
            $display("FAIL basic_hold: v=%0b Q=%0d R=%0d, want 1 4 1", if4.valid_out, if4.Q, if4.R);
        end
    endtask

    task automatic test_sequence();
        int nb; bit to;
        launch4(4'd5, 4'd7);
        drain4(nb, to);
        n_vec++;
        if (to || {if4.Q, if4.R} !== {4'd0, 4'd5}) begin
            n_err++;
            $display("FAIL seq_first: Q=%0d R=%0d timeout=%0b, want 0 5", if4.Q, if4.R, to);
        end
        launch4(4'd15, 4'd1);
        n_vec++;
        if (if4.valid_out !== 1'b0 || if4.busy_out !== 1'b1 || if4.R !== 4'd5) begin
            n_err++;
            $display("FAIL seq_start_edge: v=%0b b=%0b R=%0d, want 0 1 5",
                     if4.valid_out, if4.busy_out, if4.R);
        end
        drain4(nb, to);
        n_vec++;
        if (to || {if4.Q, if4.R} !== {4'd15, 4'd0}) begin
            n_err++;
            $display("FAIL seq_second: Q=%0d R=%0d timeout=%0b, want 15 0", if4.Q, if4.R, to);
        end
    endtask

    task automatic test_dbz();
        int nb; bit to;
        launch4(4'd9, 4'd0);
        drain4(nb, to);
        n_vec++;
        if (to || nb != 4 || {if4.Q, if4.R, if4.dbz_out} !== {4'd15, 4'd9, 1'b1}) begin
            n_err++;
            $display("FAIL dbz: Q=%0d R=%0d z=%0b busy=%0d to=%0b, want 15 9 1 4 0",
                     if4.Q, if4.R, if4.dbz_out, nb, to);
        end
    endtask

    task automatic test_restart();
        int nb; bit to;
        launch4(4'd14, 4'd5);
        if4.start = 1'b0;
        @(negedge clk);
        n_vec++;
        if (if4.valid_out !== 1'b0 || if4.busy_out !== 1'b1) begin
            n_err++;
            $display("FAIL restart_mid: v=%0b b=%0b, want 0 1", if4.valid_out, if4.busy_out);
        end
        launch4(4'd12, 4'd4);
        drain4(nb, to);
        n_vec++;
        if (to || nb != 4 || {if4.Q, if4.R, if4.dbz_out} !== {4'd3, 4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL restart_result: Q=%0d R=%0d busy=%0d to=%0b, want 3 0 4 0",
                     if4.Q, if4.R, nb, to);
        end
    endtask

    task automatic test_reset_mid();
        launch4(4'd14, 4'd5);
        if4.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_vec++;
        if ({if4.Q, if4.R, if4.valid_out, if4.busy_out} !== 10'h0) begin
            n_err++;
            $display("FAIL reset_mid: Q=%0d R=%0d v=%0b b=%0b, want all 0",
                     if4.Q, if4.R, if4.valid_out, if4.busy_out);
        end
        repeat (6) @(negedge clk);
        n_vec++;
        if (if4.valid_out !== 1'b0 || if4.busy_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset_abort: v=%0b b=%0b, want 0 0", if4.valid_out, if4.busy_out);
        end
    endtask

    task automatic test_wide();
        int nb; bit to;
        launch8(8'd255, 8'd16);
        drain8(nb, to);
        n_vec++;
        if (to || nb != 8 || {if8.Q, if8.R, if8.dbz_out} !== {8'd15, 8'd15, 1'b0}) begin
            n_err++;
            $display("FAIL wide: Q=%0d R=%0d busy=%0d to=%0b, want 15 15 8 0", if8.Q, if8.R, nb, to);
        end
    endtask

    task automatic test_random_sweep();
        int nb; bit to;
        logic [7:0] a, b, eq, er;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(0, 255));
            b = (i % 16 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            if (i % 64 == 5) b = 8'd1;
            // Occasionally hold start for two edges; the last load wins.
            if ($urandom_range(0, 3) == 0) launch8(8'($urandom), 8'($urandom));
            launch8(a, b);
            drain8(nb, to);
            eq = ref_q(a, b, 8);
            er = ref_r(a, b);
            n_vec++;
            if (to || nb != 8 || if8.Q !== eq || if8.R !== er || if8.dbz_out !== (b == 0)) begin
                n_err++;
                $display("FAIL sweep[%0d] %0d/%0d: Q=%0d R=%0d z=%0b busy=%0d to=%0b, want Q=%0d R=%0d z=%0b",
                         i, a, b, if8.Q, if8.R, if8.dbz_out, nb, to, eq, er, (b == 0));
            end
        end
    endtask

    task automatic test_random4();
        int nb; bit to;
        logic [3:0] a, b;
        for (int i = 0; i < 64; i++) begin
            a = 4'($urandom);
            b = 4'($urandom);
            launch4(a, b);
            drain4(nb, to);
            n_vec++;
            if (to || nb != 4 || if4.Q !== ref_q({4'd0, a}, {4'd0, b}, 4)
                || {4'd0, if4.R} !== ref_r({4'd0, a}, {4'd0, b}) || if4.dbz_out !== (b == 0)) begin
                n_err++;
                $display("FAIL rand4[%0d] %0d/%0d: Q=%0d R=%0d z=%0b busy=%0d to=%0b",
                         i, a, b, if4.Q, if4.R, if4.dbz_out, nb, to);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        if4.start = 1'b0; if4.A = '0; if4.B = '0;
        if8.start = 1'b0; if8.A = '0; if8.B = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_sequence();
        test_dbz();
        test_restart();
        test_reset_mid();
        test_wide();
        test_random4();
        test_random_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_udivider
`default_nettype wire
